mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one Q2.22 pipelined multiplier.
REQ-002 Parameter MUL_LAT, default 15: cycles from multiplier valid_in sampled high to the matching valid_out high.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operand-valid.
REQ-006 req_a  input  24*NREQ  signed Q2.22 operand A; requester i occupies bits [24i+23:24i].
REQ-007 req_b  input  24*NREQ  signed Q2.22 operand B; same packing as req_a.
REQ-008 req_ready  output  NREQ  one-hot grant, combinational; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 mul_a, mul_b  output  24 each  registered operands to the multiplier.
REQ-010 mul_valid_in  output  1  registered issue strobe to the multiplier.
REQ-011 mul_p  input  24  multiplier product, Q2.22, already saturated.
REQ-012 mul_valid_out  input  1  multiplier result strobe.
REQ-013 resp_valid  output  NREQ  registered one-hot result strobe to the owning requester.
REQ-014 resp_p  output  24  registered product; valid only while resp_valid is non-zero.
REQ-015 flush  input  1  single-cycle pulse; abandons all in-flight operations.
REQ-016 busy  output  1  high while any operation is in flight or state is not RUN.
REQ-017 inflight  output  ceil(log2(MUL_LAT+1))  count of issued operations whose results have not yet returned.
REQ-018 err  output  1  sticky protocol error flag.
REQ-019 err_clr  input  1  synchronous clear for err.

Function
REQ-020 State machine: RUN and FLUSH.
- RUN: grants allowed.
- FLUSH: req_ready = 0; a down-counter is loaded with MUL_LAT and decrements each cycle; return to RUN when it reaches 0.
REQ-021 flush in RUN -> enter FLUSH on the next cycle, and any handshake in the flush cycle is still issued; flush in FLUSH reloads the counter.
REQ-022 Grant is round-robin: search starts at pointer rr; the first i with req_valid[i] gets req_ready[i]; at most one grant per cycle.
REQ-023 After a transfer from i, rr becomes (i+1) mod NREQ; with no transfer, rr is unchanged.
REQ-024 On a transfer, the next cycle sets mul_valid_in=1 and mul_a/mul_b = the granted operands, and a tag {valid, i} enters a MUL_LAT-deep tag shift register aligned with mul_valid_in; otherwise mul_valid_in=0 and mul_a/mul_b hold their values.
REQ-025 Throughput: one issue per cycle sustained; the multiplier has no backpressure.
REQ-026 When mul_valid_out=1 and the tag at the shift output is valid, the next cycle drives resp_valid[tag]=1 and resp_p=mul_p.
REQ-027 inflight increments on issue and decrements on a matched return; both in the same cycle leaves it unchanged.
REQ-028 A mismatch in RUN sets err: mul_valid_out differs from the tag-valid bit at the shift output.
REQ-029 Entering FLUSH clears every tag-valid bit and zeroes inflight.
- In FLUSH, mul_valid_out is discarded, no resp_valid is produced, and no err is raised.
REQ-030 err_clr clears err; if err_clr and a new mismatch occur in the same cycle, err is set.
REQ-031 busy = (state==FLUSH) | (inflight != 0).

Reset
REQ-032 Reset values:
- state=RUN, rr=0, tag register all invalid, inflight=0, err=0.
- mul_valid_in=0, mul_a=0, mul_b=0.
- resp_valid=0, resp_p=0.
- busy=0; req_ready follows REQ-022 combinationally from req_valid.
REQ-033 Reset asserted mid-operation discards all in-flight tags; results returning after reset release produce no resp_valid and raise err.

Verification
REQ-034 Single request: req0 a=0x200000 (0.5), b=0x100000 (0.25) -> mul_valid_in at cycle 1; bench-model multiplier returns 0x080000 at cycle 1+MUL_LAT; resp_valid=0001 and resp_p=0x080000 one cycle later.
REQ-035 All four requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; inflight peaks at 8; responses return in the same order with correct owners.
REQ-036 Only requesters 1 and 3 valid with rr=2 -> grants 3,1,3,1; requesters 0 and 2 never get a ready.
REQ-037 Issue 5 ops, then pulse flush -> req_ready=0 for MUL_LAT cycles; no resp_valid; err stays 0; inflight=0; busy falls when FLUSH exits.
REQ-038 Inject mul_valid_out with an empty tag pipe in RUN -> err=1 and stays 1 until err_clr; err_clr coincident with another spurious strobe -> err remains 1.
REQ-039 Assert rst_n low with 3 ops in flight -> all outputs at reset values immediately; the returning strobes set err after reset release.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined Q2.22 multiplier among NREQ requesters, with tag-tracked result routing.
// Latency: issue one cycle after handshake; response one cycle after mul_valid_out (MUL_LAT + 2 from handshake).
// Backpressure: one-hot combinational req_ready, none while flushing; the multiplier side has no backpressure.
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 15
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NREQ-1:0]                    req_valid,
    input  logic [24*NREQ-1:0]                 req_a,
    input  logic [24*NREQ-1:0]                 req_b,
    output logic [NREQ-1:0]                    req_ready,
    output logic [23:0]                        mul_a,
    output logic [23:0]                        mul_b,
    output logic                               mul_valid_in,
    input  logic [23:0]                        mul_p,
    input  logic                               mul_valid_out,
    output logic [NREQ-1:0]                    resp_valid,
    output logic [23:0]                        resp_p,
    input  logic                               flush,
    output logic                               busy,
    output logic [$clog2(MUL_LAT+1)-1:0]       inflight,
    output logic                               err,
    input  logic                               err_clr
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MUL_LAT + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [NREQ-1:0]    gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [IW-1:0]      sel;
    logic [23:0]        iss_a, iss_b;

    logic               mul_valid_in_q;
    logic [IW-1:0]      iss_idx_q;
    logic [23:0]        mul_a_q, mul_b_q;
    logic [MUL_LAT-1:0] tag_vld_q;
    logic [IW-1:0]      tag_idx_q [MUL_LAT];
    logic [CW-1:0]      inflight_q, inflight_d;
    logic               err_q, err_d;
    logic [NREQ-1:0]    resp_valid_q, resp_dec;
    logic [23:0]        resp_p_q;

    logic               in_run, flush_enter, tag_out_vld, ret_match, mismatch;
    logic [IW-1:0]      tag_out_idx;

    assign in_run      = (state_q == ST_RUN);
    assign flush_enter = flush & in_run;
    assign tag_out_vld = tag_vld_q[MUL_LAT-1];
    assign tag_out_idx = tag_idx_q[MUL_LAT-1];
    assign ret_match   = in_run & mul_valid_out & tag_out_vld;
    assign mismatch    = in_run & (mul_valid_out != tag_out_vld);

    // Round-robin search from rr_q; only requesters presenting valid can be granted.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sel     = '0;
        if (in_run) begin
            for (int k = 0; k < NREQ; k++) begin
                sel = IW'((int'(rr_q) + k) % NREQ);
                if (!gnt_any && req_valid[sel]) begin
                    gnt_any  = 1'b1;
                    gnt[sel] = 1'b1;
                    gnt_idx  = sel;
                end
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        iss_a = '0;
        iss_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                iss_a = req_a[k*24 +: 24];
                iss_b = req_b[k*24 +: 24];
            end
        end
    end

    // Owner decode of the tag leaving the pipe.
    always_comb begin
        resp_dec = '0;
        for (int k = 0; k < NREQ; k++) begin
            resp_dec[k] = (tag_out_idx == IW'(k));
        end
    end

    // RUN/FLUSH sequencing; a flush while already flushing restarts the drain window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_run) begin
            if (flush) begin
                state_d = ST_FLUSH;
                cnt_d   = CW'(MUL_LAT);
            end
        end else if (flush) begin
            cnt_d = CW'(MUL_LAT);
        end else if (cnt_q <= CW'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Occupancy: count up when an op enters the tag pipe, down when a valid tag leaves it
    // (a tag leaving without its strobe is flagged as an error and retired anyway).
    always_comb begin
        if (flush_enter) begin
            inflight_d = '0;
        end else begin
            inflight_d = inflight_q + CW'(mul_valid_in_q) - CW'(tag_out_vld);
        end
        err_d = mismatch | (err_q & ~err_clr);
        rr_d  = gnt_any ? IW'((int'(gnt_idx) + 1) % NREQ) : rr_q;
    end

    // Control state, pointer, occupancy and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            rr_q       <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Issue register; operands hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_in_q <= 1'b0;
            iss_idx_q      <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
        end else begin
            mul_valid_in_q <= gnt_any;
            if (gnt_any) begin
                iss_idx_q <= gnt_idx;
                mul_a_q   <= iss_a;
                mul_b_q   <= iss_b;
            end
        end
    end

    // Tag pipe fed from the issue register so the tag exits together with mul_valid_out.
    // Entering FLUSH kills every older tag; the op granted in the flush cycle enters afterwards and survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_idx_q[k] <= '0;
            end
        end else begin
            if (flush_enter) begin
                tag_vld_q <= '0;
            end else begin
                tag_vld_q <= {tag_vld_q[MUL_LAT-2:0], mul_valid_in_q};
            end
            tag_idx_q[0] <= iss_idx_q;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    // Response register routed to the tag owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
            resp_p_q     <= '0;
        end else begin
            resp_valid_q <= ret_match ? resp_dec : '0;
            if (ret_match) begin
                resp_p_q <= mul_p;
            end
        end
    end

    assign req_ready    = gnt;
    assign mul_valid_in = mul_valid_in_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign resp_valid   = resp_valid_q;
    assign resp_p       = resp_p_q;
    assign inflight     = inflight_q;
    assign err          = err_q;
    assign busy         = (state_q == ST_FLUSH) | (inflight_q != '0);

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: plays the multiplier and compares every cycle against a timeline model.
// Latency: model predicts issue one cycle and response MUL_LAT+2 cycles after handshake.
// Backpressure: checks req_ready every cycle, including during flush windows and reset.
module tb_mul_arbiter;

    localparam int NREQ = 4;
    localparam int L    = 15;
    localparam int CW   = $clog2(L + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [24*NREQ-1:0]   req_a, req_b;
    logic [NREQ-1:0]      req_ready;
    logic [23:0]          mul_a, mul_b, mul_p;
    logic                 mul_valid_in, mul_valid_out;
    logic [NREQ-1:0]      resp_valid;
    logic [23:0]          resp_p;
    logic                 flush, busy, err, err_clr;
    logic [CW-1:0]        inflight;

    mul_arbiter #(.NREQ(NREQ), .MUL_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid_in(mul_valid_in),
        .mul_p(mul_p), .mul_valid_out(mul_valid_out),
        .resp_valid(resp_valid), .resp_p(resp_p),
        .flush(flush), .busy(busy), .inflight(inflight), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;      // cycle in which mul_valid_in carries the op
        int          owner;
        logic [23:0] p;
    } op_t;

    int               n_vec, n_err, cyc, flush_until, m_rr;
    bit               m_err, e_miv;
    logic [23:0]      e_ma, e_mb, e_rp;
    logic [NREQ-1:0]  e_rv;
    op_t              ops[$];
    logic [23:0]      mq[int];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] qmul(input logic [23:0] a, input logic [23:0] b);
        longint p;
        p = (longint'($signed(a)) * longint'($signed(b))) >>> 22;
        if (p > 64'sd8388607)       p = 64'sd8388607;
        else if (p < -64'sd8388608) p = -64'sd8388608;
        return p[23:0];
    endfunction

    function automatic int pick(input logic [NREQ-1:0] rv);
        for (int k = 0; k < NREQ; k++)
            if (rv[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        return -1;
    endfunction

    function automatic int exp_inflight(input int x);
        int n = 0;
        foreach (ops[j]) if (ops[j].c < x && ops[j].c + L >= x) n++;
        return n;
    endfunction

    function automatic logic [24*NREQ-1:0] rnd_ops();
        logic [24*NREQ-1:0] v;
        for (int k = 0; k < NREQ; k++) v[k*24 +: 24] = 24'($urandom);
        return v;
    endfunction

    task automatic model_reset();
        ops.delete();
        flush_until = -1;
        m_rr  = 0;
        m_err = 1'b0;
        e_miv = 1'b0;
        e_ma  = '0;
        e_mb  = '0;
        e_rv  = '0;
        e_rp  = '0;
    endtask

    task automatic check_regs();
        int n;
        n = exp_inflight(cyc);
        chk("mul_valid_in", mul_valid_in, e_miv);
        chk("mul_a", mul_a, e_ma);
        chk("mul_b", mul_b, e_mb);
        chk("resp_valid", resp_valid, e_rv);
        if (e_rv != '0) chk("resp_p", resp_p, e_rp);
        chk("err", err, m_err);
        chk("inflight", inflight, n);
        chk("busy", busy, (cyc <= flush_until) || (n != 0));
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic tick(input logic [NREQ-1:0] rv, input logic [24*NREQ-1:0] a,
                        input logic [24*NREQ-1:0] b, input bit fl, input bit clr, input bit inj);
        int g, k;
        bit found, in_fl, mis;
        logic [NREQ-1:0] eg;
        check_regs();
        req_valid     = rv;
        req_a         = a;
        req_b         = b;
        flush         = fl;
        err_clr       = clr;
        mul_valid_out = mq.exists(cyc) || inj;
        mul_p         = mq.exists(cyc) ? mq[cyc] : 24'($urandom);
        if (mul_valid_in === 1'b1) mq[cyc + L] = qmul(mul_a, mul_b);
        #1;
        in_fl = (cyc <= flush_until);
        g  = in_fl ? -1 : pick(rv);
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", req_ready, eg);
        k = -1;
        foreach (ops[j]) if (ops[j].c + L == cyc) k = j;
        found = (k >= 0);
        mis   = 1'b0;
        e_rv  = '0;
        if (!in_fl) begin
            if (mul_valid_out && found) begin
                e_rv[ops[k].owner] = 1'b1;
                e_rp = ops[k].p;
            end else if (mul_valid_out != found) begin
                mis = 1'b1;
            end
        end
        if (found) ops.delete(k);
        m_err = mis ? 1'b1 : (clr ? 1'b0 : m_err);
        if (fl) begin
            if (!in_fl) ops.delete();
            flush_until = cyc + L;
        end
        e_miv = (g >= 0);
        if (g >= 0) begin
            e_ma = a[g*24 +: 24];
            e_mb = b[g*24 +: 24];
            ops.push_back('{c: cyc + 1, owner: g, p: qmul(e_ma, e_mb)});
            m_rr = (g + 1) % NREQ;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick('0, rnd_ops(), rnd_ops(), 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset at a falling edge: outputs must drop at once.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0110;
        flush     = 1'b0;
        err_clr   = 1'b0;
        #1;
        chk("rst mul_valid_in", mul_valid_in, 0);
        chk("rst mul_a", mul_a, 0);
        chk("rst mul_b", mul_b, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_p", resp_p, 0);
        chk("rst inflight", inflight, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        chk("rst req_ready", req_ready, 4'b0010);
        model_reset();
        repeat (2) begin
            mul_valid_out = mq.exists(cyc);
            mul_p         = mq.exists(cyc) ? mq[cyc] : 24'($urandom);
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    initial begin
        logic [24*NREQ-1:0] a, b;
        logic [NREQ-1:0]    rv;
        n_vec = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        flush = 1'b0; err_clr = 1'b0; mul_valid_out = 1'b0; mul_p = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // All four requesters continuously valid for 8 cycles.
        repeat (8) tick(4'hF, rnd_ops(), rnd_ops(), 1'b0, 1'b0, 1'b0);
        idle(L + 4);

        // Single request: 0.5 * 0.25.
        a = '0; b = '0;
        a[23:0] = 24'h200000;
        b[23:0] = 24'h100000;
        tick(4'b0001, a, b, 1'b0, 1'b0, 1'b0);
        idle(L + 4);

        // Move rr to 2, then only requesters 1 and 3 compete.
        tick(4'b0010, rnd_ops(), rnd_ops(), 1'b0, 1'b0, 1'b0);
        repeat (4) tick(4'b1010, rnd_ops(), rnd_ops(), 1'b0, 1'b0, 1'b0);
        idle(L + 4);

        // Five issues, then flush while requesters keep pushing.
        repeat (5) tick(4'hF, rnd_ops(), rnd_ops(), 1'b0, 1'b0, 1'b0);
        tick(4'h0, rnd_ops(), rnd_ops(), 1'b1, 1'b0, 1'b0);
        repeat (L + 3) tick(4'hF, rnd_ops(), rnd_ops(), 1'b0, 1'b0, 1'b0);
        idle(L + 4);

        // Spurious strobes with an empty tag pipe; err_clr racing a new mismatch.
        tick('0, rnd_ops(), rnd_ops(), 1'b0, 1'b0, 1'b1);
        idle(3);
        tick('0, rnd_ops(), rnd_ops(), 1'b0, 1'b1, 1'b0);
        idle(1);
        tick('0, rnd_ops(), rnd_ops(), 1'b0, 1'b0, 1'b1);
        tick('0, rnd_ops(), rnd_ops(), 1'b0, 1'b1, 1'b1);
        idle(3);
        tick('0, rnd_ops(), rnd_ops(), 1'b0, 1'b1, 1'b0);
        idle(2);

        // Reset with three ops in flight; their results return afterwards.
        repeat (3) tick(4'b0111, rnd_ops(), rnd_ops(), 1'b0, 1'b0, 1'b0);
        idle(1);
        do_reset();
        idle(L + 4);
        tick('0, rnd_ops(), rnd_ops(), 1'b0, 1'b1, 1'b0);
        idle(2);

        // Randomized traffic with occasional flush, err_clr and spurious strobes.
        repeat (400) begin
            rv = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            tick(rv, rnd_ops(), rnd_ops(),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
        end
        idle(L + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
